vote_recorder: RTL

VOTE_RECORDER -- requirements
Module: vote_recorder

---
 rtl/vote_recorder_if.sv | 55 +++++
 rtl/vote_recorder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vote_recorder_if.sv
`default_nettype none
// ============================================================================
// Module      : vote_recorder_if
// Description : Signal bundle between the presiding-officer / voter side and
//               the vote_recorder core.
//               master : drives ballot_enable, close_poll, vote_btn and
//                        observes every status/tally signal.
//               slave  : the recorder itself (the opposite directions).
// Signals     : ballot_enable   1  arm one ballot (pulse)
//               close_poll      1  end polling (level or pulse)
//               vote_btn        3  candidate buttons, bit i = candidate i
//               ready           1  ballot armed
//               vote_ack        1  vote accepted (one-cycle pulse)
//               invalid_press   1  several buttons pressed (one-cycle pulse)
//               sat_err         1  candidate already at 15 (one-cycle pulse)
//               poll_closed     1  polling has ended
//               candidate_number_0/1/2  4  constant candidate identifiers
//               vote_count_0/1/2        4  per-candidate tallies
//               total_votes             6  accepted vote count
// Revision    : 1.0 - initial release
// ============================================================================
interface vote_recorder_if;
  logic       ballot_enable;
  logic       close_poll;
  logic [2:0] vote_btn;

  logic       ready;
  logic       vote_ack;
  logic       invalid_press;
  logic       sat_err;
  logic       poll_closed;

  logic [3:0] candidate_number_0;
  logic [3:0] candidate_number_1;
  logic [3:0] candidate_number_2;
  logic [3:0] vote_count_0;
  logic [3:0] vote_count_1;
  logic [3:0] vote_count_2;
  logic [5:0] total_votes;

  modport master (
    output ballot_enable, close_poll, vote_btn,
    input  ready, vote_ack, invalid_press, sat_err, poll_closed,
    input  candidate_number_0, candidate_number_1, candidate_number_2,
    input  vote_count_0, vote_count_1, vote_count_2, total_votes
  );

  modport slave (
    input  ballot_enable, close_poll, vote_btn,
    output ready, vote_ack, invalid_press, sat_err, poll_closed,
    output candidate_number_0, candidate_number_1, candidate_number_2,
    output vote_count_0, vote_count_1, vote_count_2, total_votes
  );
endinterface
`default_nettype wire

// File: rtl/vote_recorder.sv
`default_nettype none
// ============================================================================
// Module      : vote_recorder
// Description : Three-candidate electronic vote recorder. The presiding
//               officer arms one ballot at a time; the voter presses exactly
//               one button, which is tallied once (saturating at 15). Closing
//               the poll freezes all tallies until reset.
// Ports       : clk   in  1  single clock, rising edge
//               rst   in  1  synchronous active-high reset
//               bus   slave modport of vote_recorder_if (controls, status
//                     pulses, candidate numbers, tallies, total)
// Parameters  : CAND0_NUM/CAND1_NUM/CAND2_NUM - constant candidate numbers
// Revision    : 1.0 - initial release
// ============================================================================
module vote_recorder #(
  parameter logic [3:0] CAND0_NUM = 4'd1,
  parameter logic [3:0] CAND1_NUM = 4'd2,
  parameter logic [3:0] CAND2_NUM = 4'd3
) (
  input  logic            clk,
  input  logic            rst,
  vote_recorder_if.slave  bus
);

  localparam logic [3:0] C_COUNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    WAIT_EN = 2'd0,
    ARMED   = 2'd1,
    RELEASE = 2'd2,
    CLOSED  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0][3:0] count_q, count_d;
  logic [5:0]      total_q, total_d;
  logic            ready_q, ready_d;
  logic            ack_q, ack_d;
  logic            inv_q, inv_d;
  logic            sat_q, sat_d;
  logic            closed_q, closed_d;

  logic            w_btn_none;
  logic            w_btn_one;
  logic [2:0]      w_full;
  logic            w_sel_full;

  // --------------------------------------------------------------------------
  // Button decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_btn_none = (bus.vote_btn == 3'b000);
    w_btn_one  = 1'b0;
    case (bus.vote_btn)
      3'b001, 3'b010, 3'b100: w_btn_one = 1'b1;
      default:                w_btn_one = 1'b0;
    endcase
    for (int i = 0; i < 3; i++) begin
      w_full[i] = (count_q[i] == C_COUNT_MAX);
    end
    // Only meaningful when exactly one button is pressed.
    w_sel_full = |(bus.vote_btn & w_full);
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    total_d = total_q;
    ack_d   = 1'b0;
    inv_d   = 1'b0;
    sat_d   = 1'b0;

    if (state_q == CLOSED) begin
      state_d = CLOSED;
    end else if (bus.close_poll) begin
      // Closing wins over anything the voter does in the same cycle.
      state_d = CLOSED;
    end else begin
      case (state_q)
        WAIT_EN: begin
          if (bus.ballot_enable) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (w_btn_none) begin
            state_d = ARMED;
          end else if (!w_btn_one) begin
            // Ambiguous press: flag it and let the voter try again.
            inv_d   = 1'b1;
            state_d = ARMED;
          end else if (w_sel_full) begin
            // Ballot is consumed even though the tally cannot grow.
            sat_d   = 1'b1;
            state_d = RELEASE;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (bus.vote_btn[i]) begin
                count_d[i] = count_q[i] + 4'd1;
              end
            end
            total_d = total_q + 6'd1;
            ack_d   = 1'b1;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          // Wait for all buttons up so a held press is counted only once.
          if (w_btn_none) begin
            state_d = WAIT_EN;
          end
        end
        default: begin
          state_d = CLOSED;
        end
      endcase
    end

    // Level outputs are registered copies of the upcoming state.
    ready_d  = (state_d == ARMED);
    closed_d = (state_d == CLOSED);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_EN;
      count_q  <= '0;
      total_q  <= '0;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      inv_q    <= 1'b0;
      sat_q    <= 1'b0;
      closed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      total_q  <= total_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      inv_q    <= inv_d;
      sat_q    <= sat_d;
      closed_q <= closed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.ready              = ready_q;
  assign bus.vote_ack           = ack_q;
  assign bus.invalid_press      = inv_q;
  assign bus.sat_err            = sat_q;
  assign bus.poll_closed        = closed_q;
  assign bus.candidate_number_0 = CAND0_NUM;
  assign bus.candidate_number_1 = CAND1_NUM;
  assign bus.candidate_number_2 = CAND2_NUM;
  assign bus.vote_count_0       = count_q[0];
  assign bus.vote_count_1       = count_q[1];
  assign bus.vote_count_2       = count_q[2];
  assign bus.total_votes        = total_q;

endmodule
`default_nettype wire
